// File: rtl/seg7_if.sv
// Bus between the display-formatting logic (master) and the 7-segment scan driver (slave).
// Inputs to the driver are shadowed at frame boundaries; outputs go straight to board pins.
interface seg7_if #(
  parameter int NUM_DIGITS = 4,
  parameter int PWM_BITS   = 4
);
  logic [7*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [NUM_DIGITS-1:0]   blink_in;
  logic [PWM_BITS-1:0]     brightness;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output digits_in, dp_in, blank_in, blink_in, brightness,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  digits_in, dp_in, blank_in, blink_in, brightness,
    output seg, dp, an, frame_start
  );
endinterface

// File: rtl/seg7_scan.sv
// N-digit multiplexed 7-segment driver with dead time, PWM dimming, blink and
// frame-boundary shadow latching of the digit data.
module seg7_scan #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_COUNT = 100000,
  parameter int BLANK_CYCLES  = 1000,
  parameter int PWM_BITS      = 4,
  parameter int BLINK_FRAMES  = 125
) (
  input  logic  clk,
  input  logic  rst,
  seg7_if.slave bus
);
  localparam int CNT_W = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
  localparam int SEL_W = $clog2(NUM_DIGITS);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            cnt_next;
  logic [SEL_W-1:0]            sel;
  logic [PWM_BITS-1:0]         pwm_cnt;
  logic [BLK_W-1:0]            blink_cnt;
  logic                        blink_phase;
  logic                        slot_end;
  logic                        frame_end;
  logic                        frame_pend_p0;
  logic [NUM_DIGITS-1:0][6:0]  shadow_digits;
  logic [NUM_DIGITS-1:0]       shadow_dp;
  logic [NUM_DIGITS-1:0]       shadow_blank;
  logic [NUM_DIGITS-1:0]       shadow_blink;

  function automatic logic digit_lit(
    input logic                blank,
    input logic                blink,
    input logic                phase,
    input logic [PWM_BITS-1:0] pwm,
    input logic [PWM_BITS-1:0] duty
  );
    return !blank && !(blink && phase) && (pwm <= duty);
  endfunction

  function automatic logic [NUM_DIGITS-1:0] anode_sel_low(input logic [SEL_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (sel == SEL_LAST);
  assign cnt_next  = slot_end ? '0 : cnt + 1'b1;

  // Stage p0: slot/frame timing, blink phase and shadow capture.
  // frame_start is delayed one cycle so it coincides with the first slot-0 output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt             <= '0;
      sel             <= '0;
      pwm_cnt         <= '0;
      blink_cnt       <= '0;
      blink_phase     <= 1'b0;
      frame_pend_p0   <= 1'b0;
      bus.frame_start <= 1'b0;
      shadow_digits   <= '1;
      shadow_dp       <= '0;
      shadow_blank    <= '1;
      shadow_blink    <= '0;
    end else begin
      cnt             <= cnt_next;
      pwm_cnt         <= (cnt_next == CNT_BLANK) ? '0 : pwm_cnt + 1'b1;
      frame_pend_p0   <= frame_end;
      bus.frame_start <= frame_pend_p0;
      if (slot_end) begin
        sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
      end
      if (frame_end) begin
        shadow_digits <= bus.digits_in;
        shadow_dp     <= bus.dp_in;
        shadow_blank  <= bus.blank_in;
        shadow_blink  <= bus.blink_in;
        if (blink_cnt == BLK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Stage p1: registered pin drivers; dark during dead time, PWM off-phase or suppression.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.an  <= '1;
      bus.seg <= 7'h7F;
      bus.dp  <= 1'b1;
    end else if ((cnt >= CNT_BLANK) &&
                 digit_lit(shadow_blank[sel], shadow_blink[sel], blink_phase,
                           pwm_cnt, bus.brightness)) begin
      bus.an  <= anode_sel_low(sel);
      bus.seg <= shadow_digits[sel];
      bus.dp  <= ~shadow_dp[sel];
    end else begin
      bus.an  <= '1;
      bus.seg <= 7'h7F;
      bus.dp  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: directed scenarios plus random traffic, every cycle compared
// against a time-indexed model of the scan schedule.
`timescale 1ns/1ps
module tb_seg7_scan;
  localparam int ND    = 4;
  localparam int RC    = 20;
  localparam int BC    = 4;
  localparam int PB    = 2;
  localparam int BF    = 2;
  localparam int FRAME = ND * RC;
  localparam int MAXF  = 64;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   e = 0;
  int   fs_first = -1;
  int   lows [ND];

  logic [7*ND-1:0] snap_dig   [MAXF];
  logic [ND-1:0]   snap_dp    [MAXF];
  logic [ND-1:0]   snap_blank [MAXF];
  logic [ND-1:0]   snap_blink [MAXF];
  logic [PB-1:0]   bri_last;

  seg7_if #(.NUM_DIGITS(ND), .PWM_BITS(PB)) bus ();

  seg7_scan #(
    .NUM_DIGITS(ND), .REFRESH_COUNT(RC), .BLANK_CYCLES(BC),
    .PWM_BITS(PB), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Edge counter since reset release; inputs captured at every frame boundary.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e             = 0;
      snap_dig[0]   = '1;
      snap_dp[0]    = '0;
      snap_blank[0] = '1;
      snap_blink[0] = '0;
      bri_last      = bus.brightness;
    end else begin
      e        = e + 1;
      bri_last = bus.brightness;
      if ((e % FRAME) == 0 && (e / FRAME) < MAXF) begin
        snap_dig[e / FRAME]   = bus.digits_in;
        snap_dp[e / FRAME]    = bus.dp_in;
        snap_blank[e / FRAME] = bus.blank_in;
        snap_blink[e / FRAME] = bus.blink_in;
      end
    end
  end

  task automatic check_outputs();
    int              tick, cnt, sel, f, pwm;
    logic            lit;
    logic [7*ND-1:0] dig;
    logic [ND-1:0]   exp_an;
    logic [6:0]      exp_seg;
    logic            exp_dp, exp_fs;
    exp_an  = '1;
    exp_seg = 7'h7F;
    exp_dp  = 1'b1;
    exp_fs  = 1'b0;
    if (e > 0) begin
      tick   = e - 1;
      cnt    = tick % RC;
      sel    = (tick / RC) % ND;
      f      = tick / FRAME;
      exp_fs = (e > 1) && ((tick % FRAME) == 0);
      checks++;
      assert (f < MAXF) else begin
        errors++;
        $error("FAIL model_range frame=%0d limit=%0d", f, MAXF);
      end
      if (f >= MAXF) f = MAXF - 1;
      if (cnt >= BC) begin
        pwm = (cnt - BC) % (1 << PB);
        lit = !snap_blank[f][sel] && !(snap_blink[f][sel] && ((f / BF) % 2 == 1)) &&
              (pwm <= int'(bri_last));
        if (lit) begin
          dig         = snap_dig[f];
          exp_an[sel] = 1'b0;
          exp_seg     = dig[sel*7 +: 7];
          exp_dp      = ~snap_dp[f][sel];
        end
      end
    end
    checks++;
    assert (bus.an === exp_an) else begin
      errors++;
      $error("FAIL an e=%0d got %b want %b", e, bus.an, exp_an);
    end
    checks++;
    assert (bus.seg === exp_seg) else begin
      errors++;
      $error("FAIL seg e=%0d got %h want %h", e, bus.seg, exp_seg);
    end
    checks++;
    assert (bus.dp === exp_dp) else begin
      errors++;
      $error("FAIL dp e=%0d got %b want %b", e, bus.dp, exp_dp);
    end
    checks++;
    assert (bus.frame_start === exp_fs) else begin
      errors++;
      $error("FAIL frame_start e=%0d got %b want %b", e, bus.frame_start, exp_fs);
    end
    checks++;
    assert ($countones(~bus.an) <= 1) else begin
      errors++;
      $error("FAIL one_anode e=%0d got %b want at most one low", e, bus.an);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    checks++;
    assert (got == want) else begin
      errors++;
      $error("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic clear_lows();
    for (int k = 0; k < ND; k++) lows[k] = 0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs();
      for (int k = 0; k < ND; k++) if (bus.an[k] === 1'b0) lows[k]++;
      if (bus.frame_start === 1'b1 && fs_first < 0) fs_first = e;
    end
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        bus.digits_in = (7*ND)'($urandom);
        bus.dp_in     = ND'($urandom);
        bus.blank_in  = ND'($urandom & $urandom);
        bus.blink_in  = ND'($urandom);
      end
      if ($urandom_range(0, 19) == 0) bus.brightness = PB'($urandom);
      run_cycles(1);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.digits_in  = {7'h00, 7'h79, 7'h24, 7'h40};
    bus.dp_in      = 4'b0010;
    bus.blank_in   = 4'b0000;
    bus.blink_in   = 4'b0000;
    bus.brightness = 2'd3;
    clear_lows();
    run_cycles(3);
    rst = 1'b0;

    // Frame 0 after reset: shadows hold reset values, so fully dark.
    run_cycles(FRAME);
    for (int k = 0; k < ND; k++) check_int($sformatf("frame0_dark_an%0d", k), lows[k], 0);

    // Frame 1: normal scan at full brightness.
    clear_lows();
    run_cycles(FRAME);
    check_int("frame_start_first_edge", fs_first, FRAME + 1);
    for (int k = 0; k < ND; k++) check_int($sformatf("full_duty_an%0d", k), lows[k], 16);

    // Frame 2: half duty, digits changed mid-frame, blank/blink staged for frame 3.
    bus.brightness = 2'd1;
    clear_lows();
    run_cycles(30);
    bus.digits_in = {7'h12, 7'h02, 7'h78, 7'h10};
    run_cycles(49);
    bus.blank_in = 4'b0001;
    bus.blink_in = 4'b0100;
    run_cycles(1);
    for (int k = 0; k < ND; k++) check_int($sformatf("half_duty_an%0d", k), lows[k], 8);

    // Frames 3..8: digit 0 blanked, digit 2 blinking with a two-frame half-period.
    bus.brightness = 2'd3;
    clear_lows();
    run_cycles(6 * FRAME);
    check_int("blank_an0", lows[0], 0);
    check_int("plain_an1", lows[1], 96);
    check_int("blink_an2", lows[2], 48);
    check_int("plain_an3", lows[3], 96);

    run_random(10 * FRAME);

    // Settle to clean inputs, then hit reset at cycle 10 of slot 2.
    bus.blank_in   = '0;
    bus.blink_in   = '0;
    bus.brightness = 2'd3;
    run_cycles(FRAME - (e % FRAME));
    run_cycles(50);
    check_int("pre_reset_an", int'(bus.an), 4'b1011);
    #2 rst = 1'b1;
    #1 check_outputs();
    check_int("async_an", int'(bus.an), 4'b1111);
    check_int("async_seg", int'(bus.seg), 7'h7F);
    run_cycles(2);
    rst = 1'b0;
    clear_lows();
    run_cycles(FRAME + 1);
    for (int k = 0; k < ND; k++) check_int($sformatf("post_reset_dark_an%0d", k), lows[k], 0);
    run_cycles(FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
